// File: rtl/mux_nchan_rr.sv
// mux_nchan_rr: N-channel W-bit stream multiplexer with valid/ready handshakes.
// The channel is picked by a fixed select or by round-robin over the valid
// channels. The output is one registered stage that carries a channel tag.
module mux_nchan_rr #(
  parameter int N     = 4,
  parameter int W     = 8,
  parameter int SEL_W = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N*W-1:0]     in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic               mode,
  input  logic [SEL_W-1:0]   sel,
  output logic [W-1:0]       out_data,
  output logic [SEL_W-1:0]   out_chan,
  output logic               out_valid,
  input  logic               out_ready
);

  logic [SEL_W-1:0] rr_ptr;
  logic [SEL_W-1:0] grant;
  logic             gvalid;
  logic [W-1:0]     gdata;
  logic             load;
  logic [SEL_W-1:0] rr_grant;
  logic             rr_found;
  logic             fix_valid;
  logic [2*N-1:0]   rot;
  int unsigned      rr_off;
  int unsigned      rr_sum;

  // The output register can take a new word when it is empty or is being drained.
  assign load = !out_valid | out_ready;

  // Round-robin search: rotate the valid vector so that rr_ptr sits at bit 0,
  // then find the first set bit and map that offset back to a channel index.
  always_comb begin
    rot      = {in_valid, in_valid} >> rr_ptr;
    rr_found = 1'b0;
    rr_off   = 0;
    for (int unsigned k = 0; k < N; k++) begin
      if (!rr_found && rot[k]) begin
        rr_found = 1'b1;
        rr_off   = k;
      end
    end
    rr_sum = 32'(rr_ptr) + rr_off;
    if (rr_sum >= N) rr_sum = rr_sum - N;
    rr_grant = SEL_W'(rr_sum);
  end

  // Fixed-select validity: a sel value with no matching channel never grants.
  always_comb begin
    fix_valid = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (sel == SEL_W'(i)) fix_valid = in_valid[i];
    end
  end

  // Choose the grant for the active mode and select that channel's data.
  always_comb begin
    grant  = mode ? rr_grant : sel;
    gvalid = mode ? rr_found : fix_valid;
    gdata  = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (grant == SEL_W'(i)) gdata = in_data[i*W +: W];
    end
  end

  // One-hot ready for the granted channel. It is held low during reset.
  always_comb begin
    in_ready = '0;
    for (int unsigned i = 0; i < N; i++) begin
      in_ready[i] = !rst & load & gvalid & (grant == SEL_W'(i));
    end
  end

  // Output register and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      rr_ptr    <= '0;
    end else begin
      if (load & gvalid) begin
        out_data  <= gdata;
        out_chan  <= grant;
        out_valid <= 1'b1;
        if (mode) rr_ptr <= (grant == SEL_W'(N-1)) ? '0 : grant + 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_nchan_rr.sv
// tb_mux_nchan_rr: scoreboard bench for mux_nchan_rr. It drives an N=4 instance
// and an N=3 instance that share the clock and reset.
module tb_mux_nchan_rr;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // N=4 instance
  logic [31:0] in_data4;
  logic [3:0]  in_valid4;
  logic [3:0]  in_ready4;
  logic        mode4;
  logic [1:0]  sel4;
  logic [7:0]  out_data4;
  logic [1:0]  out_chan4;
  logic        out_valid4;
  logic        out_ready4;

  // N=3 instance
  logic [23:0] in_data3;
  logic [2:0]  in_valid3;
  logic [2:0]  in_ready3;
  logic        mode3;
  logic [1:0]  sel3;
  logic [7:0]  out_data3;
  logic [1:0]  out_chan3;
  logic        out_valid3;
  logic        out_ready3;

  mux_nchan_rr #(.N(4), .W(8), .SEL_W(2)) u4 (
    .clk(clk), .rst(rst), .in_data(in_data4), .in_valid(in_valid4),
    .in_ready(in_ready4), .mode(mode4), .sel(sel4), .out_data(out_data4),
    .out_chan(out_chan4), .out_valid(out_valid4), .out_ready(out_ready4)
  );

  mux_nchan_rr #(.N(3), .W(8), .SEL_W(2)) u3 (
    .clk(clk), .rst(rst), .in_data(in_data3), .in_valid(in_valid3),
    .in_ready(in_ready3), .mode(mode3), .sel(sel3), .out_data(out_data3),
    .out_chan(out_chan3), .out_valid(out_valid3), .out_ready(out_ready3)
  );

  typedef struct packed {
    logic [1:0] chan;
    logic [7:0] data;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  function automatic logic [7:0] data4(input int c);
    case (c)
      0: return 8'hAA;
      1: return 8'hBB;
      2: return 8'hCC;
      default: return 8'hDD;
    endcase
  endfunction

  function automatic logic [7:0] data3(input int c);
    case (c)
      0: return 8'h11;
      1: return 8'h22;
      default: return 8'h33;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid4 = '0;
    in_valid3 = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    mode4 = 1'b1; in_valid4 = 4'hF; out_ready4 = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1;
      total_cnt++;
      if (in_ready4 !== 4'b0000) $display("FAIL reset_in_ready: got %b want 0000", in_ready4);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (out_valid4 !== 1'b0 || out_data4 !== 8'h00 || out_chan4 !== 2'd0)
        $display("FAIL reset_out: got v=%b d=%h c=%0d want v=0 d=00 c=0", out_valid4, out_data4, out_chan4);
      else pass_cnt++;
    end
    rst = 1'b0;
    #1;
    total_cnt++;
    if (in_ready4 !== 4'b0001) $display("FAIL reset_first_grant: got %b want 0001", in_ready4);
    else pass_cnt++;
    sb.push_back('{chan: 2'd0, data: 8'hAA});
    tick();
    in_valid4 = '0;
    e = sb.pop_front();
    total_cnt++;
    if (out_valid4 !== 1'b1 || out_chan4 !== e.chan || out_data4 !== e.data)
      $display("FAIL reset_first_word: got v=%b c=%0d d=%h want v=1 c=%0d d=%h", out_valid4, out_chan4, out_data4, e.chan, e.data);
    else pass_cnt++;
  endtask

  task automatic test_fixed();
    do_reset();
    mode4 = 1'b0; sel4 = 2'd2; in_valid4 = 4'hF; out_ready4 = 1'b1;
    #1;
    total_cnt++;
    if (in_ready4 !== 4'b0100) $display("FAIL fixed_in_ready: got %b want 0100", in_ready4);
    else pass_cnt++;
    for (int c = 0; c < 3; c++) sb.push_back('{chan: 2'd2, data: data4(2)});
    for (int c = 0; c < 3; c++) begin
      tick();
      e = sb.pop_front();
      total_cnt++;
      if (out_valid4 !== 1'b1 || out_chan4 !== e.chan || out_data4 !== e.data)
        $display("FAIL fixed_sel2: got v=%b c=%0d d=%h want v=1 c=%0d d=%h", out_valid4, out_chan4, out_data4, e.chan, e.data);
      else pass_cnt++;
    end
    sel4 = 2'd1;
    #1;
    total_cnt++;
    if (in_ready4 !== 4'b0010) $display("FAIL fixed_sel1_ready: got %b want 0010", in_ready4);
    else pass_cnt++;
    sb.push_back('{chan: 2'd1, data: data4(1)});
    tick();
    in_valid4 = '0;
    e = sb.pop_front();
    total_cnt++;
    if (out_valid4 !== 1'b1 || out_chan4 !== e.chan || out_data4 !== e.data)
      $display("FAIL fixed_sel1: got v=%b c=%0d d=%h want v=1 c=%0d d=%h", out_valid4, out_chan4, out_data4, e.chan, e.data);
    else pass_cnt++;
  endtask

  task automatic test_rr_all();
    do_reset();
    mode4 = 1'b1; in_valid4 = 4'hF; out_ready4 = 1'b1;
    for (int c = 0; c < 6; c++) sb.push_back('{chan: 2'(c % 4), data: data4(c % 4)});
    for (int c = 0; c < 6; c++) begin
      tick();
      e = sb.pop_front();
      total_cnt++;
      if (out_valid4 !== 1'b1 || out_chan4 !== e.chan || out_data4 !== e.data)
        $display("FAIL rr_all[%0d]: got v=%b c=%0d d=%h want v=1 c=%0d d=%h", c, out_valid4, out_chan4, out_data4, e.chan, e.data);
      else pass_cnt++;
    end
    in_valid4 = '0;
    tick();
    total_cnt++;
    if (out_valid4 !== 1'b0) $display("FAIL rr_all_drain: got v=%b want 0", out_valid4);
    else pass_cnt++;
  endtask

  task automatic test_rr_sparse();
    do_reset();
    mode4 = 1'b1; in_valid4 = 4'b1010; out_ready4 = 1'b1;
    for (int c = 0; c < 4; c++) sb.push_back('{chan: (c % 2 == 0) ? 2'd1 : 2'd3, data: (c % 2 == 0) ? 8'hBB : 8'hDD});
    for (int c = 0; c < 4; c++) begin
      tick();
      e = sb.pop_front();
      total_cnt++;
      if (out_valid4 !== 1'b1 || out_chan4 !== e.chan || out_data4 !== e.data)
        $display("FAIL rr_sparse[%0d]: got v=%b c=%0d d=%h want v=1 c=%0d d=%h", c, out_valid4, out_chan4, out_data4, e.chan, e.data);
      else pass_cnt++;
    end
    in_valid4 = 4'b0010;
    for (int c = 0; c < 3; c++) sb.push_back('{chan: 2'd1, data: 8'hBB});
    for (int c = 0; c < 3; c++) begin
      tick();
      e = sb.pop_front();
      total_cnt++;
      if (out_valid4 !== 1'b1 || out_chan4 !== e.chan || out_data4 !== e.data)
        $display("FAIL rr_single[%0d]: got v=%b c=%0d d=%h want v=1 c=%0d d=%h", c, out_valid4, out_chan4, out_data4, e.chan, e.data);
      else pass_cnt++;
    end
    in_valid4 = '0;
  endtask

  task automatic test_backpressure();
    do_reset();
    mode4 = 1'b1; in_valid4 = 4'hF; out_ready4 = 1'b1;
    sb.push_back('{chan: 2'd0, data: 8'hAA});
    tick();
    out_ready4 = 1'b0;
    e = sb.pop_front();
    for (int c = 0; c < 3; c++) begin
      #1;
      total_cnt++;
      if (in_ready4 !== 4'b0000) $display("FAIL bp_in_ready[%0d]: got %b want 0000", c, in_ready4);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (out_valid4 !== 1'b1 || out_chan4 !== e.chan || out_data4 !== e.data)
        $display("FAIL bp_hold[%0d]: got v=%b c=%0d d=%h want v=1 c=%0d d=%h", c, out_valid4, out_chan4, out_data4, e.chan, e.data);
      else pass_cnt++;
    end
    // Pointer unchanged by the stall: the next grant must be channel 1.
    out_ready4 = 1'b1;
    #1;
    total_cnt++;
    if (in_ready4 !== 4'b0010) $display("FAIL bp_release_ready: got %b want 0010", in_ready4);
    else pass_cnt++;
    sb.push_back('{chan: 2'd1, data: 8'hBB});
    tick();
    e = sb.pop_front();
    total_cnt++;
    if (out_valid4 !== 1'b1 || out_chan4 !== e.chan || out_data4 !== e.data)
      $display("FAIL bp_release: got v=%b c=%0d d=%h want v=1 c=%0d d=%h", out_valid4, out_chan4, out_data4, e.chan, e.data);
    else pass_cnt++;
    // Reset while a word is held discards it.
    out_ready4 = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    in_valid4 = '0;
    total_cnt++;
    if (out_valid4 !== 1'b0 || out_data4 !== 8'h00 || out_chan4 !== 2'd0)
      $display("FAIL bp_mid_reset: got v=%b d=%h c=%0d want v=0 d=00 c=0", out_valid4, out_data4, out_chan4);
    else pass_cnt++;
    out_ready4 = 1'b1;
  endtask

  task automatic test_fixed_invalid();
    do_reset();
    mode4 = 1'b0; sel4 = 2'd2; in_valid4 = 4'hF; out_ready4 = 1'b1;
    tick();
    in_valid4 = 4'b1011;
    #1;
    total_cnt++;
    if (in_ready4 !== 4'b0000) $display("FAIL fixinv_ready: got %b want 0000", in_ready4);
    else pass_cnt++;
    for (int c = 0; c < 2; c++) begin
      tick();
      total_cnt++;
      if (out_valid4 !== 1'b0 || in_ready4 !== 4'b0000)
        $display("FAIL fixinv_drain[%0d]: got v=%b rdy=%b want v=0 rdy=0000", c, out_valid4, in_ready4);
      else pass_cnt++;
    end
    in_valid4 = '0;
  endtask

  task automatic test_n3_wrap();
    do_reset();
    mode3 = 1'b1; in_valid3 = 3'b111; out_ready3 = 1'b1;
    for (int c = 0; c < 5; c++) sb.push_back('{chan: 2'(c % 3), data: data3(c % 3)});
    for (int c = 0; c < 5; c++) begin
      tick();
      e = sb.pop_front();
      total_cnt++;
      if (out_valid3 !== 1'b1 || out_chan3 !== e.chan || out_data3 !== e.data)
        $display("FAIL n3_wrap[%0d]: got v=%b c=%0d d=%h want v=1 c=%0d d=%h", c, out_valid3, out_chan3, out_data3, e.chan, e.data);
      else pass_cnt++;
    end
    in_valid3 = '0;
  endtask

  task automatic test_n3_sel3();
    do_reset();
    mode3 = 1'b0; sel3 = 2'd3; in_valid3 = 3'b111; out_ready3 = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      total_cnt++;
      if (in_ready3 !== 3'b000) $display("FAIL n3_sel3_ready[%0d]: got %b want 000", c, in_ready3);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (out_valid3 !== 1'b0) $display("FAIL n3_sel3_valid[%0d]: got %b want 0", c, out_valid3);
      else pass_cnt++;
    end
    sel3 = 2'd2;
    sb.push_back('{chan: 2'd2, data: 8'h33});
    tick();
    e = sb.pop_front();
    total_cnt++;
    if (out_valid3 !== 1'b1 || out_chan3 !== e.chan || out_data3 !== e.data)
      $display("FAIL n3_sel2: got v=%b c=%0d d=%h want v=1 c=%0d d=%h", out_valid3, out_chan3, out_data3, e.chan, e.data);
    else pass_cnt++;
    in_valid3 = '0;
  endtask

  initial begin
    rst        = 1'b1;
    in_data4   = {8'hDD, 8'hCC, 8'hBB, 8'hAA};
    in_valid4  = '0;
    mode4      = 1'b0;
    sel4       = '0;
    out_ready4 = 1'b1;
    in_data3   = {8'h33, 8'h22, 8'h11};
    in_valid3  = '0;
    mode3      = 1'b0;
    sel3       = '0;
    out_ready3 = 1'b1;
    tick();

    test_reset();
    test_fixed();
    test_rr_all();
    test_rr_sparse();
    test_backpressure();
    test_fixed_invalid();
    test_n3_wrap();
    test_n3_sel3();

    total_cnt++;
    if (sb.size() !== 0) $display("FAIL scoreboard_empty: got %0d entries want 0", sb.size());
    else pass_cnt++;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mux_nchan_rr.md
Name: mux_nchan_rr

Overview:
- Parametrised successor to the team's 4:1 select mux.
- Generalised to N channels of W-bit data, each with a valid/ready handshake.
- Two modes: fixed-select, or round-robin over the valid channels.
- Output is a single registered stage with a valid/ready handshake and a channel tag.
- Sits between several producer streams and one consumer, for example to merge sensor or test-pattern sources onto one bus.

Parameters:
- N, 4, number of input channels (2..16).
- W, 8, data width per channel in bits.
- SEL_W, 2, select/tag width; must equal ceil(log2(N)).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- in_data  input  N*W  packed channel data; channel i occupies bits [i*W +: W].
- in_valid  input  N  per-channel valid.
- in_ready  output  N  per-channel ready; combinational.
- mode  input  1  0 = fixed select, 1 = round-robin.
- sel  input  SEL_W  channel index used in fixed mode.
- out_data  output  W  registered selected data.
- out_chan  output  SEL_W  index of the channel that produced out_data.
- out_valid  output  1  output register holds a word.
- out_ready  input  1  consumer accepts the word.

Behaviour:
- Reset:
  - Synchronous, active-high; all state clears on the clk edge where rst=1.
  - out_valid=0, out_data=0, out_chan=0, round-robin pointer rr_ptr=0.
  - in_ready is 0 while rst=1.
  - Reset mid-transfer discards the held word; no partial state survives.
- Load enable: load = !out_valid | out_ready (pass-through/pipeline behaviour, no bubble on back-to-back transfers).
- Grant selection (combinational):
  - Fixed mode: grant = sel; gvalid = in_valid[sel] & (sel < N). A sel value >= N never grants.
  - Round-robin mode: grant = first index j in the order rr_ptr, rr_ptr+1, …, wrapping modulo N, with in_valid[j]=1. gvalid = |in_valid.
- Handshake:
  - in_ready[i] = load & gvalid & (i == grant). At most one in_ready bit is high per cycle.
  - A transfer on channel i occurs when in_valid[i] & in_ready[i].
  - Upstream must hold in_data/in_valid until it sees ready.
- Output update (on a clk edge, rst=0):
  - If load & gvalid: out_data <= selected channel data, out_chan <= grant, out_valid <= 1.
  - Else if out_ready: out_valid <= 0, with out_data and out_chan held.
  - Else: hold everything.
- Latency: 1 cycle from input transfer to out_valid. Sustained throughput is 1 word/cycle when out_ready stays 1.
- Round-robin pointer:
  - On each transfer in mode 1: rr_ptr <= (grant+1) mod N. Wrap from N-1 goes to 0, also for non-power-of-2 N.
  - rr_ptr does not change in mode 0 and does not change when there is no transfer.
- Mode or sel changes:
  - Sampled combinationally each cycle and take effect for the next grant.
  - A word already in the output register is unaffected.
- Backpressure: with out_valid=1 and out_ready=0, all in_ready=0 and out_data/out_chan are held stable.
- Simultaneous accept and load (out_valid=1, out_ready=1, new grant): the old word leaves and the new word loads in the same cycle; out_valid stays 1.
- Starvation freedom (mode 1): every continuously valid channel is granted within N transfers.

Test Plan:
- Reset: assert rst for 2 cycles with all in_valid=1 -> out_valid=0, out_data=0, out_chan=0, in_ready=0 throughout; first grant after release is channel 0 in mode 1.
- Fixed mode, N=4, W=8: in_data = {8'hDD, 8'hCC, 8'hBB, 8'hAA}, all valid, sel=2, out_ready=1 -> in_ready=4'b0100; out_data=8'hCC, out_chan=2 one cycle later, every cycle. Set sel=1 -> next output is 8'hBB.
- Round-robin, all four channels valid, out_ready=1 -> out_chan sequence 0,1,2,3,0,1 on consecutive cycles with no bubbles.
- Round-robin with only channels 1 and 3 valid -> out_chan alternates 1,3,1,3. Then drop channel 3's valid -> channel 1 granted every cycle.
- Backpressure: hold out_ready=0 for 3 cycles with out_valid=1 -> out_data/out_chan stable, in_ready=0, rr_ptr unchanged. Release out_ready -> the pending word leaves and the next channel loads in the same cycle.
- Edge cases, each checked separately:
  - Fixed mode with in_valid[sel]=0 while other channels are valid -> no in_ready asserted and out_valid drops after the last word is drained.
  - Non-power-of-2 N=3, round-robin, all valid -> out_chan sequence 0,1,2,0 (wraps from 2 to 0).
  - N=3 with sel=3 in fixed mode -> never grants.
